// File: rtl/generic_bus_arbiter_if.sv
// Signal bundle between the two pipeline bus masters, the arbiter and the memory-side bus.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface generic_bus_arbiter_if;
    logic [31:0] i_addr;
    logic        i_ren;
    logic [31:0] i_rdata;
    logic        i_busy;

    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ren;
    logic        d_wen;
    logic [3:0]  d_byte_en;
    logic [31:0] d_rdata;
    logic        d_busy;

    logic [31:0] out_addr;
    logic [31:0] out_wdata;
    logic        out_ren;
    logic        out_wen;
    logic [3:0]  out_byte_en;
    logic [31:0] out_rdata;
    logic        out_busy;

    modport slave (
        input  i_addr, i_ren,
        output i_rdata, i_busy,
        input  d_addr, d_wdata, d_ren, d_wen, d_byte_en,
        output d_rdata, d_busy,
        output out_addr, out_wdata, out_ren, out_wen, out_byte_en,
        input  out_rdata, out_busy
    );

    modport master (
        output i_addr, i_ren,
        input  i_rdata, i_busy,
        output d_addr, d_wdata, d_ren, d_wen, d_byte_en,
        input  d_rdata, d_busy,
        input  out_addr, out_wdata, out_ren, out_wen, out_byte_en,
        output out_rdata, out_busy
    );
endinterface

// File: rtl/generic_bus_arbiter.sv
// Two-to-one fetch/data arbiter onto a single downstream generic bus, data has priority.
// Optional fetch anti-starvation counter is enabled by defining ARB_STARVE_GUARD_EN.
module generic_bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 CLK,
    input  logic                 nRST,
    generic_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   w_fetch_starved;

    if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_starve_limit
        $error("generic_bus_arbiter: STARVE_LIMIT must be within 1..15");
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] r_starve_cnt;

    assign w_fetch_starved = (r_starve_cnt == LIMIT) && bus.i_ren;

    // Counts data grants that overtook a waiting fetch; any grant without a waiting fetch resets it.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_starve_cnt <= 4'd0;
        end else if (r_state == IDLE) begin
            if (w_next_state == GRANT_I) begin
                r_starve_cnt <= 4'd0;
            end else if (w_next_state == GRANT_D) begin
                if (!bus.i_ren) begin
                    r_starve_cnt <= 4'd0;
                end else if (r_starve_cnt != LIMIT) begin
                    r_starve_cnt <= r_starve_cnt + 4'd1;
                end
            end
        end
    end
`else
    assign w_fetch_starved = 1'b0;
`endif

    assign bus.i_rdata = bus.out_rdata;
    assign bus.d_rdata = bus.out_rdata;

    always_comb begin
        w_next_state    = r_state;
        bus.out_addr    = 32'd0;
        bus.out_wdata   = 32'd0;
        bus.out_ren     = 1'b0;
        bus.out_wen     = 1'b0;
        bus.out_byte_en = 4'd0;
        bus.i_busy      = 1'b1;
        bus.d_busy      = 1'b1;

        unique case (r_state)
            IDLE: begin
                if (w_fetch_starved) begin
                    w_next_state = GRANT_I;
                end else if (bus.d_ren || bus.d_wen) begin
                    w_next_state = GRANT_D;
                end else if (bus.i_ren) begin
                    w_next_state = GRANT_I;
                end
            end

            GRANT_I: begin
                bus.out_addr    = bus.i_addr;
                bus.out_ren     = bus.i_ren;
                bus.out_byte_en = 4'b1111;
                // A dropped request abandons the grant without signalling completion.
                if (!bus.i_ren) begin
                    w_next_state = IDLE;
                end else if (!bus.out_busy) begin
                    bus.i_busy   = 1'b0;
                    w_next_state = IDLE;
                end
            end

            GRANT_D: begin
                bus.out_addr    = bus.d_addr;
                bus.out_wdata   = bus.d_wdata;
                bus.out_ren     = bus.d_ren;
                bus.out_wen     = bus.d_wen;
                bus.out_byte_en = bus.d_byte_en;
                if (!(bus.d_ren || bus.d_wen)) begin
                    w_next_state = IDLE;
                end else if (!bus.out_busy) begin
                    bus.d_busy   = 1'b0;
                    w_next_state = IDLE;
                end
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule
